motor_pwm_driver: RTL and testbench

- Downstream stage of the rover steering logic. Consumes the 4-bit motor command word and drives the two H-bridges (left, right).
- Per wheel motor it provides a soft-start duty ramp, PWM generation, and an enforced dead-time on every direction reversal, so the bridge legs never shoot through and the motors never see a hard reversal.

---
 rtl/rover_motor_pkg.sv | 34 +++
 rtl/motor_channel.sv | 139 +++++++++++++
 rtl/motor_pwm_driver.sv | 93 +++++++++
 tb/tb_motor_pwm_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rover_motor_pkg.sv
// rtl/rover_motor_pkg.sv - shared codes, channel states and default parameters for the motor PWM driver
package rover_motor_pkg;

  // Per-wheel direction codes as carried on the motor command word
  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_REV   = 2'b10;

  // Per-channel bridge state
  typedef enum logic [1:0] {
    ST_COAST = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2
  } chan_state_t;

  // Default build parameters
  localparam int DEF_PWM_BITS  = 8;
  localparam int DEF_DUTY_MAX  = 200;
  localparam int DEF_RAMP_STEP = 8;
  localparam int DEF_RAMP_DIV  = 1000;
  localparam int DEF_DEADTIME  = 50;

  // Code 11 is treated as coast so both legs can never be requested together
  function automatic logic [1:0] decode_req(input logic [1:0] code);
    logic [1:0] req;
    case (code)
      CMD_FWD: req = CMD_FWD;
      CMD_REV: req = CMD_REV;
      default: req = CMD_COAST;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// rtl/motor_channel.sv - one wheel: request decode, soft-start ramp, dead-time and leg drive
module motor_channel
  import rover_motor_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int DUTY_MAX  = DEF_DUTY_MAX,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int DEADTIME  = DEF_DEADTIME
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_cmd,
  input  logic                i_ramp_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic [1:0]          o_hb,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_dead
);

  localparam int TW = $clog2(DEADTIME + 1);
  localparam logic [PWM_BITS:0] STEP_W  = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS:0] MAX_W   = (PWM_BITS + 1)'(DUTY_MAX);
  localparam logic [TW-1:0]     DT_LOAD = TW'(DEADTIME - 1);

  chan_state_t         r_state;
  chan_state_t         w_state_nxt;
  logic [1:0]          r_dir;
  logic [1:0]          w_dir_nxt;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic [TW-1:0]       r_timer;
  logic [TW-1:0]       w_timer_nxt;
  logic [PWM_BITS-1:0] r_duty_eff;
  logic [PWM_BITS-1:0] w_eff;
  logic                w_pwm_on;
  logic [1:0]          w_req;
  logic [PWM_BITS:0]   w_sum;
  logic [1:0]          r_hb;
  logic                r_dead;

  assign w_req = decode_req(i_cmd);
  // Widened add so the ramp saturates instead of wrapping
  assign w_sum = {1'b0, r_duty} + STEP_W;

  // State register with ramp duty, direction and dead-time timer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_COAST;
      r_dir   <= CMD_COAST;
      r_duty  <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_duty  <= w_duty_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state logic; any transition out of RUN takes priority over a ramp tick
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_duty_nxt  = r_duty;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_COAST: begin
        w_duty_nxt = '0;
        if (w_req != CMD_COAST) begin
          w_state_nxt = ST_RUN;
          w_dir_nxt   = w_req;
        end
      end
      ST_RUN: begin
        if (w_req == CMD_COAST) begin
          w_state_nxt = ST_COAST;
          w_duty_nxt  = '0;
        end else if (w_req != r_dir) begin
          w_state_nxt = ST_DEAD;
          w_timer_nxt = DT_LOAD;
          w_duty_nxt  = '0;
        end else if (i_ramp_tick) begin
          w_duty_nxt = (w_sum > MAX_W) ? MAX_W[PWM_BITS-1:0] : w_sum[PWM_BITS-1:0];
        end
      end
      ST_DEAD: begin
        w_duty_nxt = '0;
        // Timer runs to zero regardless of request changes; only then is the request honoured
        if (r_timer == '0) begin
          if (w_req == CMD_COAST) begin
            w_state_nxt = ST_COAST;
          end else begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = w_req;
          end
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_COAST;
        w_duty_nxt  = '0;
      end
    endcase
  end

  // At the period start the fresh duty is used directly so the whole period shares one value
  assign w_eff    = (i_pwm_cnt == '0) ? r_duty : r_duty_eff;
  assign w_pwm_on = (i_pwm_cnt < w_eff);

  // Effective duty only changes on the PWM period boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty_eff <= '0;
    end else if (i_pwm_cnt == '0) begin
      r_duty_eff <= r_duty;
    end
  end

  // Registered leg drive; only the leg matching the latched direction ever pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hb   <= 2'b00;
      r_dead <= 1'b0;
    end else begin
      r_dead <= (r_state == ST_DEAD);
      if (r_state == ST_RUN) begin
        r_hb <= (r_dir == CMD_FWD) ? {w_pwm_on, 1'b0} : {1'b0, w_pwm_on};
      end else begin
        r_hb <= 2'b00;
      end
    end
  end

  assign o_hb   = r_hb;
  assign o_duty = r_duty;
  assign o_dead = r_dead;

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - two-wheel H-bridge driver with shared PWM counter and ramp prescaler
module motor_pwm_driver
  import rover_motor_pkg::*;
#(
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int DUTY_MAX  = DEF_DUTY_MAX,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int RAMP_DIV  = DEF_RAMP_DIV,
  parameter int DEADTIME  = DEF_DEADTIME
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          motor_cmd,
  output logic [1:0]          hb_l,
  output logic [1:0]          hb_r,
  output logic [PWM_BITS-1:0] duty_l,
  output logic [PWM_BITS-1:0] duty_r,
  output logic                dead_l,
  output logic                dead_r
);

  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [3:0]          r_cmd;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PW-1:0]       r_pre;
  logic                w_ramp_tick;

  assign w_ramp_tick = (r_pre == PRE_LAST);

  // Single register stage on the command word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= 4'b0000;
    end else begin
      r_cmd <= motor_cmd;
    end
  end

  // Free-running PWM counter shared by both wheels, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Ramp prescaler; the tick is the last count before wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_ramp_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  motor_channel #(
    .PWM_BITS  (PWM_BITS),
    .DUTY_MAX  (DUTY_MAX),
    .RAMP_STEP (RAMP_STEP),
    .DEADTIME  (DEADTIME)
  ) u_left (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd       (r_cmd[3:2]),
    .i_ramp_tick (w_ramp_tick),
    .i_pwm_cnt   (r_pwm_cnt),
    .o_hb        (hb_l),
    .o_duty      (duty_l),
    .o_dead      (dead_l)
  );

  motor_channel #(
    .PWM_BITS  (PWM_BITS),
    .DUTY_MAX  (DUTY_MAX),
    .RAMP_STEP (RAMP_STEP),
    .DEADTIME  (DEADTIME)
  ) u_right (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd       (r_cmd[1:0]),
    .i_ramp_tick (w_ramp_tick),
    .i_pwm_cnt   (r_pwm_cnt),
    .o_hb        (hb_r),
    .o_duty      (duty_r),
    .o_dead      (dead_r)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - self-checking bench for motor_pwm_driver
module tb_motor_pwm_driver;

  localparam int PB   = 8;
  localparam int DMAX = 200;
  localparam int STEP = 8;
  localparam int DIV  = 4;
  localparam int DT   = 50;
  localparam int PER  = 256;
  localparam int MC   = 0;
  localparam int MR   = 1;
  localparam int MD   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    motor_cmd = 4'b0000;
  logic [1:0]    hb_l, hb_r;
  logic [PB-1:0] duty_l, duty_r;
  logic          dead_l, dead_r;

  motor_pwm_driver #(
    .PWM_BITS(PB), .DUTY_MAX(DMAX), .RAMP_STEP(STEP), .RAMP_DIV(DIV), .DEADTIME(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_cmd(motor_cmd),
    .hb_l(hb_l), .hb_r(hb_r), .duty_l(duty_l), .duty_r(duty_r),
    .dead_l(dead_l), .dead_r(dead_r)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute cycle index, ramp expressed as tick count
  int         cyc;
  logic [3:0] m_creg;
  int         m_mode[2];
  int         m_dir[2];
  int         m_ticks[2];
  int         m_dead_end[2];
  int         m_per[2];
  int         e_hb[2];
  int         e_dead[2];

  function automatic int duty_of(input int t);
    int v;
    v = t * STEP;
    return (v > DMAX) ? DMAX : v;
  endfunction

  function automatic int req_of(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_creg = 4'b0000;
    for (int ch = 0; ch < 2; ch++) begin
      m_mode[ch] = MC; m_dir[ch] = 0; m_ticks[ch] = 0; m_dead_end[ch] = 0;
      m_per[ch] = 0; e_hb[ch] = 0; e_dead[ch] = 0;
    end
  endtask

  task automatic model_step();
    int req, pd, on, ph;
    logic [1:0] c;
    ph = cyc % PER;
    for (int ch = 0; ch < 2; ch++) begin
      c   = (ch == 0) ? m_creg[3:2] : m_creg[1:0];
      req = req_of(c);
      pd  = (ph == 0) ? duty_of(m_ticks[ch]) : m_per[ch];
      m_per[ch] = pd;
      on = (ph < pd) ? 1 : 0;
      e_hb[ch]   = (m_mode[ch] == MR) ? ((m_dir[ch] == 1) ? on * 2 : on) : 0;
      e_dead[ch] = (m_mode[ch] == MD) ? 1 : 0;
      case (m_mode[ch])
        MC: if (req != 0) begin m_mode[ch] = MR; m_dir[ch] = req; m_ticks[ch] = 0; end
        MR: begin
          if (req == 0) begin
            m_mode[ch] = MC; m_ticks[ch] = 0;
          end else if (req != m_dir[ch]) begin
            m_mode[ch] = MD; m_dead_end[ch] = cyc + DT; m_ticks[ch] = 0;
          end else if ((cyc % DIV) == DIV - 1 && m_ticks[ch] < 1000) begin
            m_ticks[ch]++;
          end
        end
        default: if (cyc == m_dead_end[ch]) begin
          if (req == 0) m_mode[ch] = MC;
          else begin m_mode[ch] = MR; m_dir[ch] = req; m_ticks[ch] = 0; end
        end
      endcase
    end
    m_creg = motor_cmd;
    cyc++;
  endtask

  task automatic check_all();
    chk("hb_l", int'(hb_l), e_hb[0]);
    chk("hb_r", int'(hb_r), e_hb[1]);
    chk("dead_l", int'(dead_l), e_dead[0]);
    chk("dead_r", int'(dead_r), e_dead[1]);
    chk("duty_l", int'(duty_l), duty_of(m_ticks[0]));
    chk("duty_r", int'(duty_r), duty_of(m_ticks[1]));
    chk("shoot_l", int'(hb_l == 2'b11), 0);
    chk("shoot_r", int'(hb_r == 2'b11), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input logic [3:0] c);
    @(negedge clk);
    rst_n = 1'b0;
    motor_cmd = c;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int all_out();
    return int'({hb_l, hb_r, duty_l, duty_r, dead_l, dead_r});
  endfunction

  typedef struct {
    logic [3:0] cmd;
    int         hold;
    int         dl;
    int         dr;
    int         xl;
    int         xr;
  } vec_t;

  vec_t vecs[8];
  int   n_dead, n_hb_dead, n_in1, n_in2, n_r_bad, guard;

  initial begin
    vecs[0] = '{4'b0000, 4, 0, 0, 0, 0};
    vecs[1] = '{4'b0101, 20, 40, 40, 0, 0};
    vecs[2] = '{4'b1001, 4, 0, 48, 1, 0};
    vecs[3] = '{4'b1001, 60, 24, 168, 0, 0};
    vecs[4] = '{4'b1001, 40, 104, 200, 0, 0};
    vecs[5] = '{4'b1111, 4, 0, 0, 0, 0};
    vecs[6] = '{4'b0110, 8, 16, 16, 0, 0};
    vecs[7] = '{4'b1010, 10, 0, 32, 1, 0};

    // Reset held: command toggling must not disturb outputs
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      motor_cmd = 4'($urandom_range(0, 15));
      #1;
      chk("reset_hold_outputs", all_out(), 0);
    end
    motor_cmd = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (8) step();

    // Table-driven vectors from a fresh reset
    do_reset(4'b0000);
    for (int i = 0; i < 8; i++) begin
      motor_cmd = vecs[i].cmd;
      repeat (vecs[i].hold) step();
      chk($sformatf("vec%0d duty_l", i), int'(duty_l), vecs[i].dl);
      chk($sformatf("vec%0d duty_r", i), int'(duty_r), vecs[i].dr);
      chk($sformatf("vec%0d dead_l", i), int'(dead_l), vecs[i].xl);
      chk($sformatf("vec%0d dead_r", i), int'(dead_r), vecs[i].xr);
      chk($sformatf("vec%0d hb_l", i), int'(hb_l), 0);
      chk($sformatf("vec%0d hb_r", i), int'(hb_r), 0);
    end

    // Reversal at full duty: exact dead window, then reverse leg only
    do_reset(4'b0101);
    guard = 0;
    while (duty_l != 8'(DMAX) && guard < 400) begin step(); guard++; end
    chk("ramp_reaches_max", int'(duty_l), DMAX);
    repeat (300) step();
    motor_cmd = 4'b1001;
    n_dead = 0; n_hb_dead = 0; n_r_bad = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (dead_l) begin
        n_dead++;
        if (hb_l != 2'b00) n_hb_dead++;
      end
      if (duty_r != 8'(DMAX) || dead_r) n_r_bad++;
    end
    chk("reversal_dead_len", n_dead, DT);
    chk("reversal_legs_in_dead", n_hb_dead, 0);
    n_in1 = 0; n_in2 = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (hb_l[1]) n_in1++;
      if (hb_l[0]) n_in2++;
      if (duty_r != 8'(DMAX) || dead_r) n_r_bad++;
    end
    chk("reverse_in1_high", n_in1, 0);
    chk("reverse_in2_seen", int'(n_in2 > 0), 1);
    chk("right_unaffected", n_r_bad, 0);

    // Retarget during dead-time must not restart the timer
    motor_cmd = 4'b0101;
    guard = 0;
    while (!dead_l && guard < 10) begin step(); guard++; end
    chk("retarget_dead_entered", int'(dead_l), 1);
    n_dead = 0; guard = 0;
    while (dead_l && guard < 200) begin
      n_dead++;
      if (n_dead == 5) motor_cmd = 4'b0001;
      if (n_dead == 40) motor_cmd = 4'b0101;
      step();
      guard++;
    end
    chk("retarget_dead_len", n_dead, DT);
    n_in1 = 0; n_in2 = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (hb_l[1]) n_in1++;
      if (hb_l[0]) n_in2++;
    end
    chk("retarget_fwd_in1_seen", int'(n_in1 > 0), 1);
    chk("retarget_fwd_in2_high", n_in2, 0);

    // Illegal code 11 on both pairs coasts everything
    motor_cmd = 4'b1111;
    repeat (10) step();
    chk("illegal_duty_l", int'(duty_l), 0);
    chk("illegal_duty_r", int'(duty_r), 0);
    chk("illegal_hb", int'({hb_l, hb_r}), 0);

    // Asynchronous reset pulse with left in DEAD and right in RUN
    do_reset(4'b0101);
    repeat (120) step();
    motor_cmd = 4'b1001;
    repeat (10) step();
    chk("pre_reset_dead_l", int'(dead_l), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), 0);
    motor_cmd = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("post_reset_outputs", all_out(), 0);
    repeat (200) step();
    chk("post_reset_ramp_l", int'(duty_l), DMAX);
    chk("post_reset_ramp_r", int'(duty_r), DMAX);

    // Randomized command segments against the model
    do_reset(4'b0000);
    for (int s = 0; s < 30; s++) begin
      motor_cmd = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 300)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
